// File: rtl/fp_add_pkg.sv
// Shared constants and the S1 pipeline bundle for the floating-point
// add post-processing stage (normalize, round, pack).
package fp_add_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = FRAC_W + 5;
    localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int XW      = EXP_W + 2;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    localparam logic signed [XW-1:0] EXP_TOP = XW'(EXP_MAX);

    localparam logic [1:0] SP_NORMAL = 2'b00;
    localparam logic [1:0] SP_ZERO   = 2'b01;
    localparam logic [1:0] SP_INF    = 2'b10;
    localparam logic [1:0] SP_NAN    = 2'b11;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    // mant holds fraction plus guard/round/sticky; the hidden bit is implied
    typedef struct packed {
        logic                  sign;
        logic signed [XW-1:0]  exp;
        logic [MANT_W-3:0]     mant;
        logic [1:0]            special;
        logic                  unf;
    } s1_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter for the 27-bit hidden+fraction+GRS field.
// An all-zero input reports 27.
module fp_lzc (
    input  logic [26:0] a,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (a[i]) cnt = 5'(26 - i);
        end
    end

endmodule

// File: rtl/fp_add_norm_round.sv
// Post-add stage: normalize the raw aligned sum, round to nearest even,
// and pack an IEEE-754 single with ovf/unf/inexact flags. Two-stage pipe.
module fp_add_norm_round
    import fp_add_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [1:0]        in_special,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       c,
    output logic              ovf,
    output logic              unf,
    output logic              inexact
);

    logic       s1_valid;
    logic       s2_ready;
    s1_t        s1;
    s1_t        s1_n;
    logic [4:0] lz;
    logic [26:0] norm;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    fp_lzc u_lzc (
        .a   (in_mant[26:0]),
        .cnt (lz)
    );

    always_comb begin
        s1_n         = '0;
        s1_n.sign    = in_sign;
        s1_n.special = in_special;
        if (in_mant[27]) begin
            norm     = {in_mant[27:2], |in_mant[1:0]};
            s1_n.exp = $signed({2'b00, in_exp}) + 10'sd1;
        end else begin
            norm     = in_mant[26:0] << lz;
            s1_n.exp = $signed({2'b00, in_exp}) - $signed({5'd0, lz});
        end
        s1_n.mant = norm[25:0];
        // a zero sum never gets a hidden bit after normalization
        if (in_special == SP_NORMAL) begin
            if (!norm[26]) begin
                s1_n.special = SP_ZERO;
                s1_n.sign    = 1'b0;
            end else if (s1_n.exp[XW-1] || s1_n.exp == '0) begin
                s1_n.unf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1 <= s1_n;
        end
    end

    logic                 g;
    logic                 r;
    logic                 s;
    logic                 up;
    logic [FRAC_W:0]      frac_r;
    logic signed [XW-1:0] exp_r;
    logic [31:0]          c_n;
    logic                 ovf_n;
    logic                 unf_n;
    logic                 inx_n;

    always_comb begin
        g      = s1.mant[2];
        r      = s1.mant[1];
        s      = s1.mant[0];
        up     = g & (r | s | s1.mant[3]);
        frac_r = {1'b0, s1.mant[25:3]} + {{FRAC_W{1'b0}}, up};
        exp_r  = s1.exp + {{(XW-1){1'b0}}, frac_r[FRAC_W]};
        c_n    = '0;
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        inx_n  = 1'b0;
        unique case (s1.special)
            SP_ZERO: c_n = {s1.sign, 31'h0};
            SP_INF:  c_n = {s1.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            SP_NAN:  c_n = QNAN;
            default: begin
                if (s1.unf) begin
                    c_n   = {s1.sign, 31'h0};
                    unf_n = 1'b1;
                    inx_n = 1'b1;
                end else if (exp_r >= EXP_TOP) begin
                    c_n   = {s1.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    ovf_n = 1'b1;
                    inx_n = 1'b1;
                end else begin
                    c_n   = {s1.sign, exp_r[EXP_W-1:0], frac_r[FRAC_W-1:0]};
                    inx_n = g | r | s;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inexact   <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                c       <= c_n;
                ovf     <= ovf_n;
                unf     <= unf_n;
                inexact <= inx_n;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_norm_round.sv
// Table-driven scoreboard bench for fp_add_norm_round, with hand-written
// latency, backpressure and reset-in-flight sequences.
module tb_fp_add_norm_round;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic [1:0]  sp;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } vec_t;

    localparam int NV = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic [1:0]  in_special;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic        ovf;
    logic        unf;
    logic        inexact;

    int          tests = 0;
    int          fails = 0;
    int          outs  = 0;
    logic        rand_rdy = 1'b0;
    logic [34:0] sb[$];
    logic [34:0] exp_rec;
    vec_t        tv[NV];

    always #5 clk = ~clk;

    fp_add_norm_round dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_special (in_special),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .c          (c),
        .ovf        (ovf),
        .unf        (unf),
        .inexact    (inexact)
    );

    function automatic vec_t mk(logic sg, logic [7:0] e, logic [27:0] m,
                                logic [1:0] sp, logic [31:0] r,
                                logic o, logic u, logic x);
        vec_t v;
        v.sign = sg; v.exp = e; v.mant = m; v.sp = sp;
        v.res = r; v.ovf = o; v.unf = u; v.inx = x;
        return v;
    endfunction

    task automatic check(string name, logic [34:0] act, logic [34:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got c=%h want no output", c);
            end else begin
                exp_rec = sb.pop_front();
                check($sformatf("out%0d", outs), {c, ovf, unf, inexact}, exp_rec);
            end
            outs++;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [34:0] rec(int i);
        return {tv[i].res, tv[i].ovf, tv[i].unf, tv[i].inx};
    endfunction

    task automatic drive(int i);
        in_valid   = 1'b1;
        in_sign    = tv[i].sign;
        in_exp     = tv[i].exp;
        in_mant    = tv[i].mant;
        in_special = tv[i].sp;
    endtask

    task automatic send(int i);
        bit done = 0;
        drive(i);
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(rec(i));
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: vector %0d got no in_ready want accept", i);
        end
    endtask

    task automatic drain(string name);
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check(name, 35'(sb.size()), 35'd0);
    endtask

    initial begin
        tv[0]  = mk(0, 8'd126, 28'h8000000, 2'b00, 32'h3F800000, 0, 0, 0);
        tv[1]  = mk(0, 8'd130, 28'h0100000, 2'b00, 32'h3E000000, 0, 0, 0);
        tv[2]  = mk(0, 8'd127, 28'h4000004, 2'b00, 32'h3F800000, 0, 0, 1);
        tv[3]  = mk(0, 8'd127, 28'h400000C, 2'b00, 32'h3F800002, 0, 0, 1);
        tv[4]  = mk(0, 8'd254, 28'h8000000, 2'b00, 32'h7F800000, 1, 0, 1);
        tv[5]  = mk(0, 8'd3,   28'h0000100, 2'b00, 32'h00000000, 0, 1, 1);
        tv[6]  = mk(0, 8'd0,   28'h0000000, 2'b11, 32'h7FC00000, 0, 0, 0);
        tv[7]  = mk(1, 8'd0,   28'h0000000, 2'b10, 32'hFF800000, 0, 0, 0);
        tv[8]  = mk(1, 8'd50,  28'h0000000, 2'b00, 32'h00000000, 0, 0, 0);
        tv[9]  = mk(1, 8'd129, 28'h6000000, 2'b00, 32'hC0C00000, 0, 0, 0);
        tv[10] = mk(0, 8'd127, 28'h7FFFFFC, 2'b00, 32'h40000000, 0, 0, 1);
        tv[11] = mk(0, 8'd254, 28'h7FFFFFC, 2'b00, 32'h7F800000, 1, 0, 1);
        tv[12] = mk(0, 8'd127, 28'h8000001, 2'b00, 32'h40000000, 0, 0, 1);
        tv[13] = mk(0, 8'd1,   28'h4000000, 2'b00, 32'h00800000, 0, 0, 0);
        tv[14] = mk(1, 8'd0,   28'h4000000, 2'b00, 32'h80000000, 0, 1, 1);
        tv[15] = mk(1, 8'd5,   28'h0000000, 2'b01, 32'h80000000, 0, 0, 0);
        tv[16] = mk(0, 8'd255, 28'h4000000, 2'b00, 32'h7F800000, 1, 0, 1);
        tv[17] = mk(0, 8'd127, 28'h4000006, 2'b00, 32'h3F800001, 0, 0, 1);
        tv[18] = mk(0, 8'd140, 28'h000001F, 2'b00, 32'h3B780000, 0, 0, 0);
        tv[19] = mk(0, 8'd100, 28'hFFFFFFF, 2'b00, 32'h33000000, 0, 0, 1);

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_exp     = '0;
        in_mant    = '0;
        in_special = 2'b00;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {out_valid, c, ovf, unf}, 35'd0);
        check("rst_inexact", 35'(inexact), 35'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 35'(in_ready), 35'd1);

        for (int i = 0; i < NV; i++) send(i);
        in_valid = 1'b0;
        drain("drain_table");

        rand_rdy = 1'b1;
        for (int i = NV - 1; i >= 0; i--) send(i);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        rand_rdy = 1'b0;
        #2;
        out_ready = 1'b1;
        drain("drain_random");

        @(posedge clk);
        #1;
        sb.push_back(rec(0));
        drive(0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_edge1", 35'(out_valid), 35'd0);
        @(posedge clk);
        #1;
        check("lat_edge2", 35'(out_valid), 35'd1);
        drain("drain_lat");

        begin
            int acc = 0;
            out_ready = 1'b0;
            for (int cyc = 0; cyc < 4; cyc++) begin
                drive(2 + acc);
                @(negedge clk);
                if (in_ready) begin
                    sb.push_back(rec(2 + acc));
                    acc++;
                end
                if (cyc == 3) check("stall_hold", {out_valid, c, 2'b00}, {1'b1, tv[2].res, 2'b00});
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            check("bp_accepted", 35'(acc), 35'd2);
            check("bp_in_ready", 35'(in_ready), 35'd0);
            out_ready = 1'b1;
            @(negedge clk);
            check("bp_out1", 35'(out_valid), 35'd1);
            @(negedge clk);
            check("bp_out2", 35'(out_valid), 35'd1);
            drain("drain_bp");
        end

        out_ready = 1'b0;
        send(5);
        send(6);
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_flight_valid", 35'(out_valid), 35'd0);
        check("rst_flight_ready", 35'(in_ready), 35'd1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst_flight_quiet", 35'(out_valid), 35'd0);
        send(9);
        in_valid = 1'b0;
        drain("drain_post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
